// File: rtl/sdram_arb_pkg.sv
// Shared SDRAM arbitration types and widths.
// Used by the port arbiter, the video line fetcher and the SDRAM controller.
package sdram_arb_pkg;

  localparam int unsigned SDRAM_ADDR_W = 24;
  localparam int unsigned SDRAM_DATA_W = 16;

  // Grant encoding doubles as the arbiter FSM state (IDLE / VID / CPU).
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_VID  = 2'd1,
    GNT_CPU  = 2'd2
  } gnt_t;

  // True when the CPU presents any request (read or write).
  function automatic logic cpu_req(input logic rd, input logic wr);
    return rd | wr;
  endfunction

endpackage

// File: rtl/sdram_arb_chk.sv
// Protocol checker for the SDRAM port arbiter: flags CPU read+write while
// granted and acks raised by a master that does not hold the grant.
module sdram_arb_chk
  import sdram_arb_pkg::*;
(
  input logic clk_i,
  input logic rst_i,
  input gnt_t gnt_i,
  input logic vid_ack_i,
  input logic cpu_ack_i,
  input logic cpu_rd_i,
  input logic cpu_wr_i
);

  a_cpu_rd_wr: assert property (@(posedge clk_i) disable iff (rst_i)
    !((gnt_i == GNT_CPU) && cpu_rd_i && cpu_wr_i));

  a_vid_ack_ungranted: assert property (@(posedge clk_i) disable iff (rst_i)
    !(vid_ack_i && (gnt_i != GNT_VID)));

  a_cpu_ack_ungranted: assert property (@(posedge clk_i) disable iff (rst_i)
    !(cpu_ack_i && (gnt_i != GNT_CPU)));

endmodule

// File: rtl/sdram_arb_starve_ctr.sv
// CPU anti-starvation counter: counts cycles the CPU requests without
// holding the grant and raises boost_o once MAX_WAIT cycles have elapsed.
// Only instantiated when SDRAM_ARB_CPU_BOOST_EN is defined.
module sdram_arb_starve_ctr #(
  parameter int unsigned MAX_WAIT = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_i,
  input  logic granted_i,
  output logic boost_o
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] cnt_r;

  // Saturating wait counter, cleared whenever the CPU holds the grant.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (granted_i) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (req_i && (cnt_r != MAX_C)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign boost_o = (cnt_r >= MAX_C);

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-master arbiter for the single SDRAM controller request port.
// Video has fixed priority; the grant is registered and held until the
// granted master acks. Optional feature macro: SDRAM_ARB_CPU_BOOST_EN
// (forces a CPU grant after CPU_MAX_WAIT cycles of waiting).
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = SDRAM_ADDR_W,
  parameter int unsigned DATA_W       = SDRAM_DATA_W,
  parameter int unsigned CPU_MAX_WAIT = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              vid_rd_i,
  input  logic [ADDR_W-1:0] vid_addr_i,
  output logic              vid_rdy_o,
  input  logic              vid_ack_i,
  input  logic              cpu_rd_i,
  input  logic              cpu_wr_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_rdy_o,
  input  logic              cpu_ack_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              s_rd_o,
  output logic              s_wr_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [DATA_W-1:0] s_wdata_o,
  input  logic              s_rdy_i,
  output logic              s_ack_o,
  input  logic [DATA_W-1:0] s_rdata_i,
  output gnt_t              gnt_o
);

  gnt_t state_r;
  gnt_t state_nxt_s;
  logic cpu_req_s;
  logic cpu_boost_s;

  if (CPU_MAX_WAIT < 1) begin : g_bad_max_wait
    $error("CPU_MAX_WAIT must be at least 1");
  end

  assign cpu_req_s = cpu_req(cpu_rd_i, cpu_wr_i);

`ifdef SDRAM_ARB_CPU_BOOST_EN
  sdram_arb_starve_ctr #(
    .MAX_WAIT (CPU_MAX_WAIT)
  ) u_starve_ctr (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (cpu_req_s),
    .granted_i (state_r == GNT_CPU),
    .boost_o   (cpu_boost_s)
  );
`else
  assign cpu_boost_s = 1'b0;
`endif

  // Grant register; reset aborts any burst in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= GNT_NONE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next grant: decisions only in IDLE, release only on the owner's ack.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      GNT_NONE: begin
        if (cpu_boost_s && cpu_req_s) begin
          state_nxt_s = GNT_CPU;
        end else if (vid_rd_i) begin
          state_nxt_s = GNT_VID;
        end else if (cpu_req_s) begin
          state_nxt_s = GNT_CPU;
        end else begin
          state_nxt_s = GNT_NONE;
        end
      end
      GNT_VID: begin
        if (vid_ack_i) begin
          state_nxt_s = GNT_NONE;
        end else begin
          state_nxt_s = GNT_VID;
        end
      end
      GNT_CPU: begin
        if (cpu_ack_i) begin
          state_nxt_s = GNT_NONE;
        end else begin
          state_nxt_s = GNT_CPU;
        end
      end
      default: state_nxt_s = GNT_NONE;
    endcase
  end

  // Route the granted master to the controller port; everything idle otherwise.
  always_comb begin
    s_rd_o    = 1'b0;
    s_wr_o    = 1'b0;
    s_addr_o  = {ADDR_W{1'b0}};
    s_wdata_o = {DATA_W{1'b0}};
    s_ack_o   = 1'b0;
    vid_rdy_o = 1'b0;
    cpu_rdy_o = 1'b0;
    rdata_o   = {DATA_W{1'b0}};
    case (state_r)
      GNT_VID: begin
        s_rd_o    = vid_rd_i;
        s_addr_o  = vid_addr_i;
        s_ack_o   = vid_ack_i;
        vid_rdy_o = s_rdy_i;
        rdata_o   = s_rdata_i;
      end
      GNT_CPU: begin
        // A write wins if the CPU illegally raises both strobes.
        s_wr_o    = cpu_wr_i;
        s_rd_o    = cpu_rd_i & ~cpu_wr_i;
        s_addr_o  = cpu_addr_i;
        s_wdata_o = cpu_wdata_i;
        s_ack_o   = cpu_ack_i;
        cpu_rdy_o = s_rdy_i;
        rdata_o   = s_rdata_i;
      end
      default: begin
        s_rd_o = 1'b0;
      end
    endcase
  end

  assign gnt_o = state_r;

  sdram_arb_chk u_chk (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .gnt_i     (state_r),
    .vid_ack_i (vid_ack_i),
    .cpu_ack_i (cpu_ack_i),
    .cpu_rd_i  (cpu_rd_i),
    .cpu_wr_i  (cpu_wr_i)
  );

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with a read-data scoreboard.
module tb_sdram_port_arbiter;
  import sdram_arb_pkg::*;

  localparam int AW = 24;
  localparam int DW = 16;
`ifdef SDRAM_ARB_CPU_BOOST_EN
  localparam int MW = 8;
`else
  localparam int MW = 256;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          vid_rd_i, vid_ack_i, cpu_rd_i, cpu_wr_i, cpu_ack_i, s_rdy_i;
  logic [AW-1:0] vid_addr_i, cpu_addr_i;
  logic [DW-1:0] cpu_wdata_i, s_rdata_i;
  logic          vid_rdy_o, cpu_rdy_o, s_rd_o, s_wr_o, s_ack_o;
  logic [DW-1:0] rdata_o, s_wdata_o;
  logic [AW-1:0] s_addr_o;
  gnt_t          gnt_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          to_vid;
    logic [DW-1:0] data;
  } beat_t;
  beat_t sb_q[$];

  sdram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CPU_MAX_WAIT(MW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .vid_rd_i(vid_rd_i), .vid_addr_i(vid_addr_i), .vid_rdy_o(vid_rdy_o), .vid_ack_i(vid_ack_i),
    .cpu_rd_i(cpu_rd_i), .cpu_wr_i(cpu_wr_i), .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
    .cpu_rdy_o(cpu_rdy_o), .cpu_ack_i(cpu_ack_i), .rdata_o(rdata_o),
    .s_rd_o(s_rd_o), .s_wr_o(s_wr_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
    .s_rdy_i(s_rdy_i), .s_ack_o(s_ack_o), .s_rdata_i(s_rdata_i), .gnt_o(gnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled at the falling edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    @(negedge clk_i);
  endtask

  // Present one controller word and record who should receive it.
  task automatic send_beat(input logic to_vid);
    beat_t b;
    s_rdy_i   = 1'b1;
    s_rdata_i = DW'($urandom);
    b.to_vid  = to_vid;
    b.data    = s_rdata_i;
    sb_q.push_back(b);
  endtask

  // Pop the scoreboard whenever either master sees a valid word.
  task automatic observe();
    beat_t b;
    if (vid_rdy_o || cpu_rdy_o) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_rdy", 32'(vid_rdy_o | cpu_rdy_o), 32'd0);
      end else begin
        b = sb_q.pop_front();
        check("sb_vid_rdy", 32'(vid_rdy_o), 32'(b.to_vid));
        check("sb_cpu_rdy", 32'(cpu_rdy_o), 32'(!b.to_vid));
        check("sb_rdata", 32'(rdata_o), 32'(b.data));
      end
    end
  endtask

  initial begin
    logic got_cpu;
    int   wait_cyc;

    rst_i = 1'b1;
    vid_rd_i = 1'b0; vid_ack_i = 1'b0; vid_addr_i = '0;
    cpu_rd_i = 1'b0; cpu_wr_i = 1'b0; cpu_ack_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0;
    s_rdy_i = 1'b0; s_rdata_i = '0;

    // Reset state
    settle();
    check("rst_gnt", 32'(gnt_o), 32'(GNT_NONE));
    check("rst_s_rd", 32'(s_rd_o), 32'd0);
    check("rst_s_wr", 32'(s_wr_o), 32'd0);
    check("rst_rdy", 32'({vid_rdy_o, cpu_rdy_o}), 32'd0);
    step();
    rst_i = 1'b0;

    // Video burst of 64 words at 0x800000
    step();
    vid_rd_i = 1'b1; vid_addr_i = 24'h800000;
    settle();
    check("t2_req_gnt", 32'(gnt_o), 32'(GNT_NONE));
    check("t2_req_s_rd", 32'(s_rd_o), 32'd0);
    step();
    settle();
    check("t2_gnt", 32'(gnt_o), 32'(GNT_VID));
    check("t2_s_rd", 32'(s_rd_o), 32'd1);
    check("t2_s_addr", 32'(s_addr_o), 32'h800000);
    check("t2_s_wr", 32'(s_wr_o), 32'd0);
    for (int i = 0; i < 64; i++) begin
      step();
      send_beat(1'b1);
      settle();
      check("t2_vid_rdy", 32'(vid_rdy_o), 32'd1);
      check("t2_cpu_rdy", 32'(cpu_rdy_o), 32'd0);
      observe();
      if ((i % 16) == 15) begin
        step();
        s_rdy_i = 1'b0;
        settle();
        check("t2_gap_rdy", 32'(vid_rdy_o), 32'd0);
      end
    end
    step();
    s_rdy_i = 1'b0; vid_ack_i = 1'b1; vid_rd_i = 1'b0;
    settle();
    check("t2_s_ack", 32'(s_ack_o), 32'd1);
    step();
    vid_ack_i = 1'b0;
    settle();
    check("t2_idle", 32'(gnt_o), 32'(GNT_NONE));
    check("t2_idle_s_rd", 32'(s_rd_o), 32'd0);
    check("t2_sb_empty", 32'(sb_q.size()), 32'd0);

    // Contention: video wins, CPU write follows after one idle cycle
    step();
    vid_rd_i = 1'b1; vid_addr_i = 24'h000040;
    cpu_wr_i = 1'b1; cpu_addr_i = 24'h123456; cpu_wdata_i = 16'hBEEF;
    settle();
    check("t3_req_gnt", 32'(gnt_o), 32'(GNT_NONE));
    step();
    send_beat(1'b1);
    settle();
    check("t3_gnt_vid", 32'(gnt_o), 32'(GNT_VID));
    check("t3_vid_s_wr", 32'(s_wr_o), 32'd0);
    check("t3_vid_addr", 32'(s_addr_o), 32'h000040);
    observe();
    step();
    s_rdy_i = 1'b0; vid_ack_i = 1'b1; vid_rd_i = 1'b0;
    settle();
    check("t3_vid_ack", 32'(s_ack_o), 32'd1);
    step();
    vid_ack_i = 1'b0;
    settle();
    check("t3_turnaround", 32'(gnt_o), 32'(GNT_NONE));
    check("t3_turn_s_wr", 32'(s_wr_o), 32'd0);
    step();
    settle();
    check("t3_gnt_cpu", 32'(gnt_o), 32'(GNT_CPU));
    check("t3_s_wr", 32'(s_wr_o), 32'd1);
    check("t3_s_rd", 32'(s_rd_o), 32'd0);
    check("t3_s_wdata", 32'(s_wdata_o), 32'hBEEF);
    check("t3_s_addr", 32'(s_addr_o), 32'h123456);
    step();
    send_beat(1'b0);
    settle();
    check("t3_cpu_rdy", 32'(cpu_rdy_o), 32'd1);
    check("t3_vid_rdy", 32'(vid_rdy_o), 32'd0);
    observe();

    // No preemption: video request while CPU holds the grant
    step();
    s_rdy_i = 1'b0; vid_rd_i = 1'b1; vid_addr_i = 24'h000100;
    for (int k = 0; k < 3; k++) begin
      settle();
      check("t4_hold_cpu", 32'(gnt_o), 32'(GNT_CPU));
      step();
    end
    cpu_ack_i = 1'b1; cpu_wr_i = 1'b0;
    settle();
    check("t4_cpu_ack", 32'(s_ack_o), 32'd1);
    step();
    cpu_ack_i = 1'b0;
    settle();
    check("t4_idle", 32'(gnt_o), 32'(GNT_NONE));
    step();
    settle();
    check("t4_gnt_vid", 32'(gnt_o), 32'(GNT_VID));
    check("t4_vid_addr", 32'(s_addr_o), 32'h000100);

    // Video drops rd before ack: grant is held until the ack
    step();
    vid_rd_i = 1'b0;
    settle();
    check("t4_drop_gnt", 32'(gnt_o), 32'(GNT_VID));
    check("t4_drop_s_rd", 32'(s_rd_o), 32'd0);
    step();
    settle();
    check("t4_drop_hold", 32'(gnt_o), 32'(GNT_VID));
    step();
    vid_ack_i = 1'b1;
    settle();
    check("t4_drop_ack", 32'(s_ack_o), 32'd1);
    step();
    vid_ack_i = 1'b0;
    settle();
    check("t4_drop_idle", 32'(gnt_o), 32'(GNT_NONE));

    // Starvation: video re-requests back-to-back while CPU read is held
    step();
    vid_rd_i = 1'b1; vid_addr_i = 24'h000200; cpu_rd_i = 1'b1; cpu_addr_i = 24'h000300;
    got_cpu = 1'b0;
    wait_cyc = 0;
    for (int c = 0; c < 60; c++) begin
      settle();
      if (gnt_o == GNT_CPU) begin
        got_cpu = 1'b1;
        wait_cyc = c;
        break;
      end
      step();
      vid_ack_i = (gnt_o == GNT_VID);
    end
`ifdef SDRAM_ARB_CPU_BOOST_EN
    check("t5_boost_grant", 32'(got_cpu), 32'd1);
    check("t5_boost_not_early", 32'(wait_cyc >= MW), 32'd1);
    step();
    vid_ack_i = 1'b0; cpu_ack_i = 1'b1; cpu_rd_i = 1'b0;
    step();
    cpu_ack_i = 1'b0;
`else
    check("t5_no_cpu_grant", 32'(got_cpu), 32'd0);
    step();
    vid_ack_i = 1'b0; cpu_rd_i = 1'b0;
`endif

    // Reset in the middle of a video burst clears outputs in the same cycle
    for (int w = 0; w < 6; w++) begin
      settle();
      if (gnt_o == GNT_VID) break;
      step();
    end
    check("t1_pre_gnt_vid", 32'(gnt_o), 32'(GNT_VID));
    step();
    send_beat(1'b1);
    #2;
    check("t1_pre_vid_rdy", 32'(vid_rdy_o), 32'd1);
    observe();
    rst_i = 1'b1;
    #1;
    check("t1_rst_s_rd", 32'(s_rd_o), 32'd0);
    check("t1_rst_gnt", 32'(gnt_o), 32'(GNT_NONE));
    check("t1_rst_vid_rdy", 32'(vid_rdy_o), 32'd0);
    vid_rd_i = 1'b0; s_rdy_i = 1'b0;
    step();
    rst_i = 1'b0;
    check("t1_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
